// File: rtl/tdm_demux_pkg.sv
// Shared types and helpers for the TDM demultiplexer.
// Frame state plus the lane-index width function.
package tdm_demux_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   // Clamped to 1 so a degenerate lane count never produces a zero-width index.
   function automatic int idx_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry output register for a single demux lane.
// Load wins over drain; the data word is kept after a drain.
module demux_lane_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             drain,
   output logic             valid,
   output logic [WIDTH-1:0] q
);

   logic             valid_reg;
   logic [WIDTH-1:0] q_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= 1'b0;
         q_reg     <= '0;
      end else if (load) begin
         valid_reg <= 1'b1;
         q_reg     <= data;
      end else if (valid_reg && drain) begin
         valid_reg <= 1'b0;
      end
   end

   assign valid = valid_reg;
   assign q     = q_reg;

endmodule

// File: rtl/tdm_demux.sv
// Round-robin demultiplexer: steers a serial word stream into LANES
// one-entry output registers, re-aligning to lane 0 on start-of-frame.
module tdm_demux
   import tdm_demux_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int LANES = 4,
   localparam int IW    = idx_w(LANES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_sof,
   output logic [LANES-1:0]       out_valid,
   input  logic [LANES-1:0]       out_ready,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [IW-1:0]          lane_ptr,
   output logic                   frame_done,
   output logic                   sof_err
);

   localparam logic [IW-1:0] LAST = IW'(LANES - 1);

   state_t        state_reg, state_next;
   logic [IW-1:0] lane_ptr_reg, lane_ptr_next;
   logic          frame_done_reg, frame_done_next;
   logic          sof_err_reg, sof_err_next;
   logic [IW-1:0] tgt;
   logic          accept;

   assign tgt      = in_sof ? '0 : lane_ptr_reg;
   // A full lane that drains this same cycle frees its slot for the new word.
   assign in_ready = ~out_valid[tgt] | out_ready[tgt];
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_next      = state_reg;
      lane_ptr_next   = lane_ptr_reg;
      frame_done_next = 1'b0;
      sof_err_next    = 1'b0;
      if (accept) begin
         lane_ptr_next = (tgt == LAST) ? '0 : tgt + IW'(1);
         case (state_reg)
            IDLE: begin
               if (tgt == '0 && LANES > 1) state_next = FILL;
            end
            FILL: begin
               if (tgt == LAST) begin
                  state_next      = IDLE;
                  frame_done_next = 1'b1;
               end
               if (in_sof) sof_err_next = 1'b1;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         lane_ptr_reg   <= '0;
         frame_done_reg <= 1'b0;
         sof_err_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         lane_ptr_reg   <= lane_ptr_next;
         frame_done_reg <= frame_done_next;
         sof_err_reg    <= sof_err_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .load  (accept && (tgt == IW'(gi))),
            .data  (in_data),
            .drain (out_ready[gi]),
            .valid (out_valid[gi]),
            .q     (out_data[gi*WIDTH +: WIDTH])
         );
      end
   endgenerate

   assign lane_ptr   = lane_ptr_reg;
   assign frame_done = frame_done_reg;
   assign sof_err    = sof_err_reg;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: a per-lane array model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_tdm_demux;

   localparam int W = 8;
   localparam int L = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_sof = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic [L-1:0]  out_ready = '0;
   logic          in_ready;
   logic [L-1:0]  out_valid;
   logic [L*W-1:0] out_data;
   logic [1:0]    lane_ptr;
   logic          frame_done;
   logic          sof_err;

   int vec_cnt = 0;
   int err_cnt = 0;

   tdm_demux #(.WIDTH(W), .LANES(L)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sof     (in_sof),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .lane_ptr   (lane_ptr),
      .frame_done (frame_done),
      .sof_err    (sof_err)
   );

   always #5 clk = ~clk;

   // Model: each lane is a held word plus a flag; the pointer is the next lane index.
   bit         mv[L];
   logic [7:0] md[L];
   int         mptr = 0;
   bit         mfd = 0;
   bit         mse = 0;

   initial begin
      for (int i = 0; i < L; i++) begin
         mv[i] = 0;
         md[i] = '0;
      end
   end

   always @(posedge clk or posedge rst) begin
      int t;
      bit acc;
      if (rst) begin
         for (int i = 0; i < L; i++) begin
            mv[i] = 0;
            md[i] = '0;
         end
         mptr = 0;
         mfd  = 0;
         mse  = 0;
      end else begin
         t   = in_sof ? 0 : mptr;
         acc = in_valid && (!mv[t] || out_ready[t]);
         for (int i = 0; i < L; i++) begin
            if (acc && i == t) begin
               mv[i] = 1;
               md[i] = in_data;
            end else if (mv[i] && out_ready[i]) begin
               mv[i] = 0;
            end
         end
         mfd = acc && (t == L - 1);
         mse = acc && in_sof && (mptr != 0);
         if (acc) mptr = (t + 1) % L;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [L-1:0]   ev;
      logic [L*W-1:0] ed;
      int             t;
      for (int i = 0; i < L; i++) begin
         ev[i]          = mv[i];
         ed[i*W +: W]   = md[i];
      end
      t = in_sof ? 0 : mptr;
      check("cyc_out_valid", 32'(out_valid), 32'(ev));
      check("cyc_out_data", out_data, ed);
      check("cyc_lane_ptr", 32'(lane_ptr), 32'(mptr));
      check("cyc_frame_done", 32'(frame_done), 32'(mfd));
      check("cyc_sof_err", 32'(sof_err), 32'(mse));
      check("cyc_in_ready", 32'(in_ready), 32'(!mv[t] || out_ready[t]));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic sof, input logic [7:0] d);
      in_valid = v;
      in_sof   = sof;
      in_data  = d;
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;

      // Scenario 1: build out_valid=0101, then async reset between edges.
      out_ready = 4'b0010;
      drive(1, 1, 8'h01); tick();
      drive(1, 0, 8'h02); tick();
      drive(1, 0, 8'h03); tick();
      drive(0, 0, 8'h00);
      check("s1_valid_0101", 32'(out_valid), 32'h5);
      check("s1_ptr_3", 32'(lane_ptr), 32'd3);
      rst = 1'b1;
      #1;
      check("s1_rst_valid", 32'(out_valid), 32'h0);
      check("s1_rst_data", out_data, 32'h0);
      check("s1_rst_ptr", 32'(lane_ptr), 32'd0);
      tick();
      rst = 1'b0;

      // Scenario 2: straight frame with all consumers stalled.
      out_ready = 4'b0000;
      drive(1, 1, 8'h11); tick();
      drive(1, 0, 8'h22); tick();
      drive(1, 0, 8'h33); tick();
      drive(1, 0, 8'h44); tick();
      drive(0, 0, 8'h00);
      check("s2_valid", 32'(out_valid), 32'hF);
      check("s2_data", out_data, 32'h44332211);
      check("s2_fd_pulse", 32'(frame_done), 32'd1);
      check("s2_ptr", 32'(lane_ptr), 32'd0);
      tick();
      check("s2_fd_clear", 32'(frame_done), 32'd0);

      // Scenario 3: backpressure on lane 1, then same-cycle drain+load.
      out_ready = 4'b1101;
      drive(1, 1, 8'h55);
      #1;
      check("s3_draining_ready", 32'(in_ready), 32'd1);
      tick();
      drive(1, 0, 8'h66);
      #1;
      check("s3_blocked", 32'(in_ready), 32'd0);
      tick();
      check("s3_hold_ptr", 32'(lane_ptr), 32'd1);
      check("s3_hold_data", 32'(out_data[15:8]), 32'h22);
      out_ready[1] = 1'b1;
      #1;
      check("s3_unblocked", 32'(in_ready), 32'd1);
      tick();
      drive(0, 0, 8'h00);
      check("s3_new_data", 32'(out_data[15:8]), 32'h66);
      check("s3_valid1", 32'(out_valid[1]), 32'd1);
      check("s3_ptr", 32'(lane_ptr), 32'd2);

      // Scenario 4: start-of-frame arriving mid-frame.
      out_ready = 4'b1111;
      drive(1, 1, 8'hA0); tick();
      drive(1, 0, 8'hA1); tick();
      drive(1, 1, 8'hB0); tick();
      drive(0, 0, 8'h00);
      check("s4_sof_err", 32'(sof_err), 32'd1);
      check("s4_lane0", 32'(out_data[7:0]), 32'hB0);
      check("s4_lane1", 32'(out_data[15:8]), 32'hA1);
      check("s4_ptr", 32'(lane_ptr), 32'd1);
      check("s4_no_fd", 32'(frame_done), 32'd0);

      // Scenario 5: 12 streaming words with every consumer ready.
      for (int k = 1; k <= 12; k++) begin
         drive(1, k == 1, 8'(8'hC0 + k - 1));
         #1;
         check("s5_ready", 32'(in_ready), 32'd1);
         tick();
         check("s5_fd", 32'(frame_done), 32'((k % 4) == 0));
         check("s5_lane_data", 32'(out_data[((k - 1) % 4)*W +: W]), 32'(8'hC0 + k - 1));
      end
      drive(0, 0, 8'h00);

      // Scenario 6: lane 3 drains with no load; its word stays put.
      check("s6_full", 32'(out_valid[3]), 32'd1);
      tick();
      check("s6_drained", 32'(out_valid[3]), 32'd0);
      check("s6_data_kept", 32'(out_data[31:24]), 32'hCB);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
